// File: rtl/mcycle_arbiter_pkg.sv
// Shared definitions for the multi-cycle unit arbiter: FSM encoding and
// ALUControl op-codes for the multiply unit.
package mcycle_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;

endpackage

// File: rtl/mcycle_arbiter_rr_arb2.sv
// Two-way round-robin pick with a last-served pointer; after reset the
// pointer says "1 served last" so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic [1:0] gnt_o,
  output logic       winner_o
);

  logic last_q, last_d;

  always_comb begin
    winner_o = 1'b0;
    gnt_o    = 2'b00;
    last_d   = last_q;
    if (req_i[0] && req_i[1]) winner_o = ~last_q;
    else if (req_i[1])        winner_o = 1'b1;
    if (req_i != 2'b00) gnt_o = winner_o ? 2'b10 : 2'b01;
    if (update_i)       last_d = served_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/mcycle_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle unit.
// Optional WAIT watchdog built in when MCYCLE_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | accept a request (Gnt pulse), latch op/operands and owner
// ISSUE | UStart pulse to the shared unit
// WAIT  | first cycle ignores UBusy, then wait for UBusy low
// DONE  | Result valid, owner's Done pulse, pointer update
module mcycle_arbiter
  import mcycle_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             MReset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [OPW-1:0]   Op0,
  input  logic [OPW-1:0]   Op1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic [WIDTH-1:0] Result,
  output logic             UStart,
  output logic [OPW-1:0]   UOp,
  output logic [WIDTH-1:0] UA,
  output logic [WIDTH-1:0] UB,
  input  logic             UBusy,
  input  logic [WIDTH-1:0] UResult,
  output logic             Err
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             first_q, first_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       arb_req, arb_gnt;
  logic             arb_win, in_done;

`ifdef MCYCLE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign Err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign Err = 1'b0;
`endif

  // Grants are combinational in IDLE; gating with MReset keeps them low in reset.
  assign arb_req = (state_q == IDLE && MReset) ? {Req1, Req0} : 2'b00;
  assign in_done = (state_q == DONE);

  rr_arb2 u_rr_arb2 (
    .clk_i    (CLK),
    .rst_ni   (MReset),
    .req_i    (arb_req),
    .update_i (in_done),
    .served_i (owner_q),
    .gnt_o    (arb_gnt),
    .winner_o (arb_win)
  );

  assign Gnt0   = arb_gnt[0];
  assign Gnt1   = arb_gnt[1];
  assign UStart = (state_q == ISSUE);
  assign UOp    = op_q;
  assign UA     = a_q;
  assign UB     = b_q;
  assign Done0  = in_done && !owner_q;
  assign Done1  = in_done && owner_q;
  assign Result = result_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    first_d  = first_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef MCYCLE_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          owner_d = arb_win;
          op_d    = arb_win ? Op1 : Op0;
          a_d     = arb_win ? A1  : A0;
          b_d     = arb_win ? B1  : B0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b1;
        state_d = WAIT;
`ifdef MCYCLE_TIMEOUT_EN
        cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
      end
      WAIT: begin
        first_d = 1'b0;
        if (!first_q && !UBusy) begin
          result_d = UResult;
          state_d  = DONE;
        end
`ifdef MCYCLE_TIMEOUT_EN
        else if (cnt_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MReset) begin
    if (!MReset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      first_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      first_q  <= first_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef MCYCLE_TIMEOUT_EN
  always_ff @(posedge CLK or negedge MReset) begin
    if (!MReset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Directed bench for mcycle_arbiter: vector table plus hand sequences for
// contention, back-to-back service, reset mid-WAIT and a stuck unit.
module tb_mcycle_arbiter;
  import mcycle_arbiter_pkg::*;

  logic        CLK, MReset;
  logic        Req0, Req1;
  logic [2:0]  Op0, Op1;
  logic [31:0] A0, B0, A1, B1;
  logic        Gnt0, Gnt1, Done0, Done1, UStart, Err, UBusy;
  logic [2:0]  UOp;
  logic [31:0] Result, UA, UB, UResult;

  int          n_cmp = 0;
  int          n_err = 0;

  // shared-unit model: busy for busy_len cycles after UStart, result = UA*UB
  int          busy_len = 0;
  int          busy_cnt = 0;
  logic        stuck = 1'b0;
  logic [31:0] unit_res = '0;

  mcycle_arbiter #(.WIDTH(32), .OPW(3), .TIMEOUT(8)) dut (
    .CLK(CLK), .MReset(MReset),
    .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1), .Result(Result),
    .UStart(UStart), .UOp(UOp), .UA(UA), .UB(UB),
    .UBusy(UBusy), .UResult(UResult), .Err(Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (UStart) begin
      busy_cnt <= busy_len;
      unit_res <= UA * UB;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign UBusy   = stuck | (busy_cnt != 0);
  assign UResult = unit_res;

  typedef struct {
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int          busy;
    logic        win;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Entered and left at the drive point (just after a posedge).
  task automatic run_vec(input int idx, input vec_t v);
    int          t_g, t_d;
    logic        who;
    logic [2:0]  op_e;
    logic [31:0] a_e, b_e, res_seen;
    bit          start_bad, hold_bad, other_bad;
    Req0 = v.req0; Req1 = v.req1;
    Op0 = v.op0; A0 = v.a0; B0 = v.b0;
    Op1 = v.op1; A1 = v.a1; B1 = v.b1;
    busy_len = v.busy;
    t_g = -1; who = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (Gnt0 || Gnt1) begin
        t_g = n;
        who = Gnt1;
        chk($sformatf("v%0d_gnt_onehot", idx), {Gnt0, Gnt1}, {~v.win, v.win});
        break;
      end
      @(posedge CLK); #1;
    end
    chk($sformatf("v%0d_gnt_seen", idx), (t_g >= 0), 1'b1);
    chk($sformatf("v%0d_winner", idx), who, v.win);
    op_e = who ? v.op1 : v.op0;
    a_e  = who ? v.a1  : v.a0;
    b_e  = who ? v.b1  : v.b0;
    @(posedge CLK); #1;
    Req0 = 1'b0; Req1 = 1'b0;
    t_d = -1; start_bad = 0; hold_bad = 0; other_bad = 0; res_seen = '0;
    for (int k = 1; k < 100; k++) begin
      @(negedge CLK);
      if (UStart !== (k == 1)) start_bad = 1;
      if (UOp !== op_e || UA !== a_e || UB !== b_e) hold_bad = 1;
      if (Done0 || Done1) begin
        t_d = k;
        if ({Done1, Done0} !== (v.win ? 2'b10 : 2'b01)) other_bad = 1;
        res_seen = Result;
        break;
      end
    end
    chk($sformatf("v%0d_ustart", idx), start_bad, 1'b0);
    chk($sformatf("v%0d_operand_hold", idx), hold_bad, 1'b0);
    chk($sformatf("v%0d_latency", idx), t_d, v.lat);
    chk($sformatf("v%0d_done_owner", idx), other_bad, 1'b0);
    chk($sformatf("v%0d_result", idx), res_seen, v.res);
    @(negedge CLK);
    chk($sformatf("v%0d_result_hold", idx), {Done0, Done1, Result}, {2'b00, v.res});
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    MReset = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge CLK);
    MReset = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int g_t [3];
    int d_t [3];
    logic g_w [3];
    int ng, nd, t_g, t_d;
    bit bad;

    vecs[0] = '{1'b1, 1'b0, OP_MUL, OP_MULU, 32'd2,   32'd2,   32'd0,        32'd0,        32, 1'b0, 32'd4,     35};
    vecs[1] = '{1'b1, 1'b1, OP_MUL, OP_MULU, 32'd11,  32'd11,  32'd3,        32'd5,        3,  1'b1, 32'd15,    6};
    vecs[2] = '{1'b1, 1'b1, OP_MUL, OP_MULU, 32'd7,   32'd6,   32'd1,        32'd1,        1,  1'b0, 32'd42,    4};
    vecs[3] = '{1'b0, 1'b1, OP_MUL, OP_MULU, 32'd0,   32'd0,   32'hfffffffe, 32'hfffffffe, 0,  1'b1, 32'd4,     4};
    vecs[4] = '{1'b1, 1'b0, OP_MUL, OP_MULU, 32'd100, 32'd200, 32'd0,        32'd0,        5,  1'b0, 32'd20000, 8};
    vecs[5] = '{1'b1, 1'b1, OP_MUL, OP_MULU, 32'd1,   32'd2,   32'd9,        32'd9,        2,  1'b1, 32'd81,    5};

    MReset = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    Op0 = '0; Op1 = '0; A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (2) @(negedge CLK);
    Req0 = 1'b1; Req1 = 1'b1;
    #1;
    chk("rst_outputs", {Gnt0, Gnt1, Done0, Done1, UStart, Err, Result, UOp, UA, UB}, '0);
    chk("rst_state", dut.state_q, IDLE);
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge CLK);
    MReset = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // contended rounds from reset: 0, then 1 right after Done0, then 0
    do_reset();
    Op0 = OP_MUL; A0 = 32'd5; B0 = 32'd6;
    Op1 = OP_MULU; A1 = 32'd7; B1 = 32'd8;
    busy_len = 2;
    Req0 = 1'b1; Req1 = 1'b1;
    ng = 0; nd = 0;
    for (int c = 0; c < 80 && ng < 3; c++) begin
      @(negedge CLK);
      if (Done0 || Done1) begin
        if (nd < 3) d_t[nd] = c;
        if (nd == 0) chk("rr_first_result", Result, 32'd30);
        nd++;
      end
      if (Gnt0 || Gnt1) begin
        g_t[ng] = c;
        g_w[ng] = Gnt1;
        ng++;
      end
    end
    chk("rr_grant_count", ng, 3);
    if (ng == 3 && nd >= 2) begin
      chk("rr_first_winner", g_w[0], 1'b0);
      chk("rr_second_winner", g_w[1], 1'b1);
      chk("rr_third_winner", g_w[2], 1'b0);
      chk("rr_second_after_done", g_t[1] - d_t[0], 1);
      chk("rr_third_after_done", g_t[2] - d_t[1], 1);
    end
    @(posedge CLK); #1;
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (10) @(posedge CLK);
    #1;

    // back-to-back service of requester 1
    Op1 = OP_MULU; A1 = 32'hfffffffe; B1 = 32'hfffffffe;
    busy_len = 10;
    Req1 = 1'b1;
    ng = 0; bad = 0;
    for (int c = 0; c < 100 && ng < 3; c++) begin
      @(negedge CLK);
      if (ng > 0 && (UOp !== OP_MULU || UA !== 32'hfffffffe || UB !== 32'hfffffffe)) bad = 1;
      if (Done1 && Result !== 32'd4) bad = 1;
      if (Gnt1) begin
        g_t[ng] = c;
        ng++;
      end
    end
    chk("b2b_grant_count", ng, 3);
    chk("b2b_operands_and_result", bad, 1'b0);
    if (ng == 3) begin
      chk("b2b_gap1", g_t[1] - g_t[0], 14);
      chk("b2b_gap2", g_t[2] - g_t[1], 14);
    end
    @(posedge CLK); #1;
    Req1 = 1'b0;
    repeat (20) @(posedge CLK);
    #1;

    // reset 10 cycles into busy
    Op0 = OP_MUL; A0 = 32'd3; B0 = 32'd3;
    busy_len = 32;
    Req0 = 1'b1;
    t_g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (Gnt0) begin t_g = n; break; end
    end
    chk("rstmid_gnt_seen", (t_g >= 0), 1'b1);
    @(posedge CLK); #1;
    Req0 = 1'b0;
    repeat (12) @(negedge CLK);
    chk("rstmid_in_wait", UBusy && !Done0 && (UA == 32'd3), 1'b1);
    Req0 = 1'b1;
    MReset = 1'b0;
    #1;
    chk("rstmid_outputs", {Gnt0, Gnt1, Done0, Done1, UStart, Err, Result, UOp, UA, UB}, '0);
    chk("rstmid_state", dut.state_q, IDLE);
    Req0 = 1'b0;
    @(negedge CLK);
    MReset = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (Done0 || Done1 || Err) bad = 1;
    end
    chk("rstmid_no_done", bad, 1'b0);
    @(posedge CLK); #1;

    // unit stuck busy
    stuck = 1'b1;
    Req0 = 1'b1;
    t_g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (Gnt0) begin t_g = n; break; end
    end
    chk("stuck_gnt_seen", (t_g >= 0), 1'b1);
    @(posedge CLK); #1;
    Req0 = 1'b0;
    t_d = -1; bad = 0;
    for (int k = 1; k < 40; k++) begin
      @(negedge CLK);
      if (Done0 || Done1 || Err) begin
        if (t_d < 0) begin
          t_d = k;
`ifdef MCYCLE_TIMEOUT_EN
          chk("timeout_flags", {Err, Done0, Done1}, 3'b110);
          chk("timeout_result", Result, 32'd0);
`endif
        end else begin
          bad = 1;
        end
      end
    end
`ifdef MCYCLE_TIMEOUT_EN
    chk("timeout_latency", t_d, 10);
    chk("timeout_single_pulse", bad, 1'b0);
`else
    chk("stuck_no_done_no_err", t_d, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want end before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
